encoder_type_1: RTL

Sequential float-to-code encoder: accepts an IEEE-754 single-precision value and produces the compact code whose decode is that value, i.e. the exact integers 0.0 to 12.0 map to codes 0 to 12. It is the transmit-side counterpart of the type-1 code decoder and sits at the boundary where floating-point coefficients are packed into CODE_WIDTH-bit symbols for storage or transfer. Conversion is done with an iterative one-bit-per-cycle shifter, not a lookup. Any value that is not exactly representable is flagged as an error.

---
 rtl/pqc_fp_pkg.sv | 36 +++
 rtl/fp32_classify.sv | 25 ++
 rtl/encoder_type_1.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pqc_fp_pkg.sv
// Shared FP32 field layout, code layout and encoder state
// definitions for the type-1 code path.
package pqc_fp_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int FP_SIGN_POS = 31;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_BIAS     = 127;
    localparam int FP_EXP_MAX  = FP_BIAS + 3;
    localparam int FP_EXP_ALL1 = 255;

    localparam int CODE_MAX   = 12;
    localparam int SIG_W      = FP_MAN_W + 1;
    localparam int CNT_W      = 5;
    localparam int SHIFT_BASE = FP_BIAS + FP_MAN_W;

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        SHIFT,
        RANGE
    } enc_state_e;

    typedef struct packed {
        logic                s;
        logic [FP_EXP_W-1:0] e;
        logic [FP_MAN_W-1:0] m;
    } fp32_t;

    function automatic int code_mag_w(input int code_width);
        return code_width - 2;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier: zero detect, encodability
// screen and the shift count that aligns the integer part.
module fp32_classify
    import pqc_fp_pkg::*;
(
    input  logic [FP_WIDTH-1:0] word,
    output logic                is_zero,
    output logic                is_invalid,
    output logic [CNT_W-1:0]    shift_count
);

    fp32_t f;

    assign f       = word;
    assign is_zero = (f.e == '0) && (f.m == '0);

    assign is_invalid = f.s
                     || (int'(f.e) == FP_EXP_ALL1)
                     || (int'(f.e) < FP_BIAS)
                     || (int'(f.e) > FP_EXP_MAX);

    // Only meaningful for exponents 127..130, giving 20..23.
    assign shift_count = CNT_W'(SHIFT_BASE - int'(f.e));

endmodule

// File: rtl/encoder_type_1.sv
// Sequential float-to-code encoder: shifts the significand one
// bit per cycle, tracking lost bits to reject non-integers.
module encoder_type_1
    import pqc_fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CODE_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  encode_start,
    input  logic [DATA_WIDTH-1:0] inp_value,
    output logic                  code_ready,
    output logic [CODE_WIDTH-1:0] out_code,
    output logic                  code_error
);

    localparam int MAG_W = code_mag_w(CODE_WIDTH);

    enc_state_e            state_q, state_d;
    logic [FP_WIDTH-1:0]   word_q, word_d;
    logic [SIG_W-1:0]      sig_q, sig_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sticky_q, sticky_d;
    logic                  ready_d;
    logic [CODE_WIDTH-1:0] code_d;
    logic                  err_d;

    logic                  is_zero;
    logic                  is_invalid;
    logic [CNT_W-1:0]      shift_count;

    fp32_classify u_classify (
        .word        (word_q),
        .is_zero     (is_zero),
        .is_invalid  (is_invalid),
        .shift_count (shift_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            sig_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            code_ready <= 1'b0;
            out_code   <= '0;
            code_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            sig_q      <= sig_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            code_ready <= ready_d;
            out_code   <= code_d;
            code_error <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        ready_d  = 1'b0;
        code_d   = out_code;
        err_d    = code_error;
        unique case (state_q)
            IDLE: begin
                if (encode_start) begin
                    word_d  = inp_value[FP_WIDTH-1:0];
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (is_zero) begin
                    code_d  = '0;
                    err_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (is_invalid) begin
                    code_d  = '0;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    sig_d    = {1'b1, word_q[FP_MAN_W-1:0]};
                    cnt_d    = shift_count;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sticky_d = sticky_q | sig_q[0];
                sig_d    = sig_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RANGE;
                end
            end
            RANGE: begin
                // Any bit shifted out means a fractional input.
                if (sticky_q || (sig_q > SIG_W'(CODE_MAX))) begin
                    code_d = '0;
                    err_d  = 1'b1;
                end else begin
                    code_d = CODE_WIDTH'(sig_q[MAG_W-1:0]);
                    err_d  = 1'b0;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
